// File: rtl/wb_write_queue_pkg.sv
// Shared sizing defaults and small helpers for the writeback queue.
package wb_write_queue_pkg;

    localparam int WBQ_DEPTH  = 4;
    localparam int WBQ_DATA_W = 32;
    localparam int WBQ_ADDR_W = 5;

    // Number of results entering the queue this cycle (0, 1 or 2).
    function automatic logic [1:0] wbq_enq_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/wb_write_queue_bypass_match.sv
// Searches the pending queue entries for a register address and returns the
// data of the youngest match (closest to the tail). Register $0 never hits.
module wb_bypass_match
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [DATA_W-1:0] entry_data [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              hit_s;
    logic [DATA_W-1:0] data_s;
    logic [PTR_W-1:0]  idx_s;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_s  = 1'b0;
        data_s = {DATA_W{1'b0}};
        idx_s  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (query_addr != {ADDR_W{1'b0}}) &&
                (entry_addr[idx_s] == query_addr)) begin
                hit_s  = 1'b1;
                data_s = entry_data[idx_s];
            end else begin
                hit_s  = hit_s;
                data_s = data_s;
            end
        end
    end

    assign hit  = hit_s;
    assign data = data_s;

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: accepts memory and ALU results (memory is the older one),
// drains one register-file write per cycle from the head, and offers a
// bypass lookup over entries still waiting to be written.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       rf_write_en,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          byp_addr_1,
    input  logic [ADDR_W-1:0]          byp_addr_2,
    output logic                       byp_hit_1,
    output logic                       byp_hit_2,
    output logic [DATA_W-1:0]          byp_data_1,
    output logic [DATA_W-1:0]          byp_data_2,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r, tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              rf_write_en_r;
    logic [ADDR_W-1:0] rf_write_addr_r;
    logic [DATA_W-1:0] rf_write_data_r;

    logic              mem_ready_s, alu_ready_s, mem_enq_s, alu_enq_s, pop_s;
    logic [1:0]        enq_cnt_s;
    logic [PTR_W-1:0]  mem_slot_s, alu_slot_s, head_next_s, tail_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] wr_addr_next_s;
    logic [DATA_W-1:0] wr_data_next_s;

    // Readiness from the start-of-cycle count, enqueue decisions and next pointers.
    always_comb begin
        mem_ready_s = (count_r <= CNT_W'(DEPTH - 1));
        if (count_r <= CNT_W'(DEPTH - 2)) begin
            alu_ready_s = 1'b1;
        end else if (count_r == CNT_W'(DEPTH - 1)) begin
            // Last free slot goes to the older memory result unless it targets $0.
            alu_ready_s = ~(mem_valid & (mem_addr != {ADDR_W{1'b0}}));
        end else begin
            alu_ready_s = 1'b0;
        end
        mem_enq_s    = mem_valid & mem_ready_s & (mem_addr != {ADDR_W{1'b0}});
        alu_enq_s    = alu_valid & alu_ready_s & (alu_addr != {ADDR_W{1'b0}});
        pop_s        = (count_r != {CNT_W{1'b0}});
        enq_cnt_s    = wbq_enq_count(mem_enq_s, alu_enq_s);
        mem_slot_s   = tail_r;
        alu_slot_s   = tail_r + PTR_W'(mem_enq_s);
        tail_next_s  = tail_r + PTR_W'(enq_cnt_s);
        head_next_s  = head_r + PTR_W'(pop_s);
        count_next_s = count_r + CNT_W'(enq_cnt_s) - CNT_W'(pop_s);
    end

    // Entry at the head after this edge; it may be a result written this same edge.
    always_comb begin
        wr_addr_next_s = {ADDR_W{1'b0}};
        wr_data_next_s = {DATA_W{1'b0}};
        if (count_next_s != {CNT_W{1'b0}}) begin
            if (mem_enq_s && (mem_slot_s == head_next_s)) begin
                wr_addr_next_s = mem_addr;
                wr_data_next_s = mem_data;
            end else if (alu_enq_s && (alu_slot_s == head_next_s)) begin
                wr_addr_next_s = alu_addr;
                wr_data_next_s = alu_data;
            end else begin
                wr_addr_next_s = addr_r[head_next_s];
                wr_data_next_s = data_r[head_next_s];
            end
        end else begin
            wr_addr_next_s = {ADDR_W{1'b0}};
            wr_data_next_s = {DATA_W{1'b0}};
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r          <= {PTR_W{1'b0}};
            tail_r          <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            rf_write_en_r   <= 1'b0;
            rf_write_addr_r <= {ADDR_W{1'b0}};
            rf_write_data_r <= {DATA_W{1'b0}};
        end else begin
            head_r          <= head_next_s;
            tail_r          <= tail_next_s;
            count_r         <= count_next_s;
            rf_write_en_r   <= (count_next_s != {CNT_W{1'b0}});
            rf_write_addr_r <= wr_addr_next_s;
            rf_write_data_r <= wr_data_next_s;
        end
    end

    // Queue storage; contents survive reset because occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (mem_enq_s) begin
            addr_r[mem_slot_s] <= mem_addr;
            data_r[mem_slot_s] <= mem_data;
        end
        if (alu_enq_s) begin
            addr_r[alu_slot_s] <= alu_addr;
            data_r[alu_slot_s] <= alu_data;
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_1 (
        .entry_addr (addr_r),
        .entry_data (data_r),
        .head       (head_r),
        .count      (count_r),
        .query_addr (byp_addr_1),
        .hit        (byp_hit_1),
        .data       (byp_data_1)
    );

    wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_2 (
        .entry_addr (addr_r),
        .entry_data (data_r),
        .head       (head_r),
        .count      (count_r),
        .query_addr (byp_addr_2),
        .hit        (byp_hit_2),
        .data       (byp_data_2)
    );

    assign mem_ready     = mem_ready_s;
    assign alu_ready     = alu_ready_s;
    assign rf_write_en   = rf_write_en_r;
    assign rf_write_addr = rf_write_addr_r;
    assign rf_write_data = rf_write_data_r;
    assign pending       = count_r;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed, table-driven bench for wb_write_queue (DEPTH 4, 32-bit data, 5-bit addresses).
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid, mem_ready, alu_ready;
    logic [4:0]  mem_addr, alu_addr, rf_write_addr, byp_addr_1, byp_addr_2;
    logic [31:0] mem_data, alu_data, rf_write_data, byp_data_1, byp_data_2;
    logic        rf_write_en, byp_hit_1, byp_hit_2;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    wb_write_queue dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
        .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
        .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic [4:0]  b1, b2;
        logic        mr, ar, en; logic [4:0] wa; logic [31:0] wd;
        logic        h1; logic [31:0] d1;
        logic        h2; logic [31:0] d2;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input int mv, ma, md, av, aa, ad, b1, b2,
                                input int mr, ar, en, wa, wd, h1, d1, h2, d2, pend);
        vec_t v;
        v.mv = 1'(mv); v.ma = 5'(ma); v.md = 32'(md);
        v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
        v.b1 = 5'(b1); v.b2 = 5'(b2);
        v.mr = 1'(mr); v.ar = 1'(ar); v.en = 1'(en); v.wa = 5'(wa); v.wd = 32'(wd);
        v.h1 = 1'(h1); v.d1 = 32'(d1); v.h2 = 1'(h2); v.d2 = 32'(d2); v.pend = 3'(pend);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] b1, input logic [4:0] b2);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        byp_addr_1 = b1; byp_addr_2 = b2;
    endtask

    initial begin
        // Rows: inputs for the cycle, then outputs expected during that cycle.
        //            mv ma md          av aa ad          b1 b2  mr ar en wa wd           h1 d1           h2 d2      pend
        vecs[0]  = mk(0, 0, 0,          0, 0, 0,          5, 0,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[1]  = mk(0, 0, 0,          1, 5, 32'hDEADBEEF, 5, 0, 1, 1, 0, 0, 0,          0, 0,           0, 0,      0);
        vecs[2]  = mk(0, 0, 0,          0, 0, 0,          5, 0,  1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,    1);
        vecs[3]  = mk(0, 0, 0,          0, 0, 0,          5, 0,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[4]  = mk(1, 3, 32'h11,     1, 3, 32'h22,     3, 5,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[5]  = mk(0, 0, 0,          0, 0, 0,          3, 5,  1, 1, 1, 3, 32'h11,      1, 32'h22,      0, 0,      2);
        vecs[6]  = mk(0, 0, 0,          0, 0, 0,          3, 5,  1, 1, 1, 3, 32'h22,      1, 32'h22,      0, 0,      1);
        vecs[7]  = mk(0, 0, 0,          0, 0, 0,          3, 5,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[8]  = mk(1, 0, 32'h1,      1, 0, 32'hFFFF,   0, 3,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[9]  = mk(0, 0, 0,          0, 0, 0,          0, 3,  1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[10] = mk(1, 8, 32'h108,    1, 16, 32'h110,   8, 16, 1, 1, 0, 0, 0,           0, 0,           0, 0,      0);
        vecs[11] = mk(1, 9, 32'h109,    1, 17, 32'h111,   8, 16, 1, 1, 1, 8, 32'h108,     1, 32'h108,     1, 32'h110, 2);
        vecs[12] = mk(1, 10, 32'h10A,   1, 18, 32'h112,   9, 8,  1, 0, 1, 16, 32'h110,    1, 32'h109,     0, 0,      3);
        vecs[13] = mk(1, 11, 32'h10B,   1, 18, 32'h112,   17, 10, 1, 0, 1, 9, 32'h109,    1, 32'h111,     1, 32'h10A, 3);
        vecs[14] = mk(1, 12, 32'h10C,   1, 18, 32'h112,   11, 18, 1, 0, 1, 17, 32'h111,   1, 32'h10B,     0, 0,      3);
        vecs[15] = mk(1, 13, 32'h10D,   1, 18, 32'h112,   12, 9, 1, 0, 1, 10, 32'h10A,    1, 32'h10C,     0, 0,      3);
        vecs[16] = mk(1, 0, 32'h77,     1, 18, 32'h112,   13, 18, 1, 1, 1, 11, 32'h10B,   1, 32'h10D,     0, 0,      3);
        vecs[17] = mk(0, 0, 0,          0, 0, 0,          18, 12, 1, 1, 1, 12, 32'h10C,   1, 32'h112,     1, 32'h10C, 3);
        vecs[18] = mk(0, 0, 0,          0, 0, 0,          18, 13, 1, 1, 1, 13, 32'h10D,   1, 32'h112,     1, 32'h10D, 2);
        vecs[19] = mk(0, 0, 0,          0, 0, 0,          18, 0, 1, 1, 1, 18, 32'h112,    1, 32'h112,     0, 0,      1);
        vecs[20] = mk(0, 0, 0,          0, 0, 0,          18, 0, 1, 1, 0, 0, 0,           0, 0,           0, 0,      0);

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #12;
        chk("reset_en", 32'(rf_write_en), 32'd0);
        chk("reset_addr", 32'(rf_write_addr), 32'd0);
        chk("reset_data", rf_write_data, 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: single write, same-address collision, $0, back-pressure.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].av, vecs[i].aa, vecs[i].ad,
                  vecs[i].b1, vecs[i].b2);
            #2;
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].mr));
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ar));
            chk($sformatf("v%0d_wr_en", i), 32'(rf_write_en), 32'(vecs[i].en));
            if (vecs[i].en) begin
                chk($sformatf("v%0d_wr_addr", i), 32'(rf_write_addr), 32'(vecs[i].wa));
                chk($sformatf("v%0d_wr_data", i), rf_write_data, vecs[i].wd);
            end
            chk($sformatf("v%0d_hit1", i), 32'(byp_hit_1), 32'(vecs[i].h1));
            chk($sformatf("v%0d_data1", i), byp_data_1, vecs[i].d1);
            chk($sformatf("v%0d_hit2", i), 32'(byp_hit_2), 32'(vecs[i].h2));
            chk($sformatf("v%0d_data2", i), byp_data_2, vecs[i].d2);
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
            @(posedge clk); #1;
        end

        // Wrap-around: ten back-to-back single ALU results, addresses 1..10.
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'h5000 + 32'(k), 5'(k - 1), 5'd0);
            else         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(k - 1), 5'd0);
            #2;
            chk($sformatf("wrap%0d_alu_ready", k), 32'(alu_ready), 32'd1);
            chk($sformatf("wrap%0d_pending", k), 32'(pending), (k == 1) ? 32'd0 : 32'd1);
            if (k > 1) begin
                chk($sformatf("wrap%0d_wr_en", k), 32'(rf_write_en), 32'd1);
                chk($sformatf("wrap%0d_wr_addr", k), 32'(rf_write_addr), 32'(k - 1));
                chk($sformatf("wrap%0d_wr_data", k), rf_write_data, 32'h5000 + 32'(k - 1));
                chk($sformatf("wrap%0d_hit1", k), 32'(byp_hit_1), 32'd1);
                chk($sformatf("wrap%0d_data1", k), byp_data_1, 32'h5000 + 32'(k - 1));
            end
            @(posedge clk); #1;
        end
        #2;
        chk("wrap_end_en", 32'(rf_write_en), 32'd0);
        chk("wrap_end_pending", 32'(pending), 32'd0);
        @(posedge clk); #1;

        // Mid-cycle reset with three entries pending.
        drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd2, 32'h202, 5'd2, 5'd5);
        @(posedge clk); #1;
        drive(1'b1, 5'd4, 32'h204, 1'b1, 5'd5, 32'h205, 5'd2, 5'd5);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5);
        #2;
        chk("prerst_pending", 32'(pending), 32'd3);
        chk("prerst_hit1", 32'(byp_hit_1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(rf_write_en), 32'd0);
        chk("rst_wr_addr", 32'(rf_write_addr), 32'd0);
        chk("rst_wr_data", rf_write_data, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_hit1", 32'(byp_hit_1), 32'd0);
        chk("rst_data1", byp_data_1, 32'd0);
        chk("rst_hit2", 32'(byp_hit_2), 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_wr_en", 32'(rf_write_en), 32'd0);
        chk("postrst_pending", 32'(pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
